// File: rtl/src_sync_rx_module_pkg.sv
// Shared defaults and write-FSM encoding for the source-synchronous receiver.
package src_sync_rx_module_pkg;

  localparam int unsigned WIDTH_DEF    = 4;
  localparam int unsigned AW_DEF       = 3;
  localparam int unsigned LOCK_CNT_DEF = 4;

  typedef enum logic [0:0] {
    ST_LOCK = 1'b0,
    ST_RUN  = 1'b1
  } wr_state_e;

endpackage

// File: rtl/src_sync_rx_module_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear.
module sync2_module #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [WIDTH-1:0] D_i,
  output logic [WIDTH-1:0] Q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two register stages to resolve metastability on the incoming bus.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= D_i;
      sync_q <= meta_q;
    end
  end

  assign Q_o = sync_q;

endmodule

// File: rtl/src_sync_rx_module.sv
// Source-synchronous receiver: captures RX_Din on the forwarded RX_CLK,
// buffers it in a Gray-pointer async FIFO and presents it on CLK.
module src_sync_rx_module
  import src_sync_rx_module_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             RX_CLK,
  input  logic [WIDTH-1:0] RX_Din,
  output logic [WIDTH-1:0] Dout,
  output logic             Dout_Valid,
  input  logic             Dout_Ready,
  output logic             Overflow,
  input  logic             Ovf_Clr,
  output logic             Locked
);

  localparam int unsigned PW    = AW + 1;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned LCW   = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  // ---------------- reset synchronizers ----------------
  logic rx_rst_n;
  logic clk_rst_n;

  sync2_module #(.WIDTH(1)) u_rx_rst_sync (
    .CLK (RX_CLK),
    .RSTn(RSTn),
    .D_i (1'b1),
    .Q_o (rx_rst_n)
  );

  sync2_module #(.WIDTH(1)) u_clk_rst_sync (
    .CLK (CLK),
    .RSTn(RSTn),
    .D_i (1'b1),
    .Q_o (clk_rst_n)
  );

  // ---------------- RX_CLK domain ----------------
  wr_state_e        state_q;
  logic [LCW-1:0]   lock_cnt_q;
  logic             run_q;
  logic [WIDTH-1:0] cap_q;
  logic             cap_vld_q;
  logic [PW-1:0]    wr_bin_q, wr_bin_d;
  logic [PW-1:0]    wr_gray_q, wr_gray_d;
  logic [PW-1:0]    rd_gray_rx;
  logic             ovf_flag_q, ovf_flag_d;
  logic             ovf_tgl_q, ovf_tgl_d;
  logic             full_c, wr_en_c, drop_c;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write FSM: swallow the first LOCK_CNT edges, then stay in RUN until reset.
  always_ff @(posedge RX_CLK or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q    <= ST_LOCK;
      lock_cnt_q <= '0;
      run_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_LOCK: begin
          if (lock_cnt_q == LCW'(LOCK_CNT - 1)) begin
            state_q <= ST_RUN;
            run_q   <= 1'b1;
          end else begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
          end
        end
        ST_RUN:  state_q <= ST_RUN;
        default: state_q <= ST_LOCK;
      endcase
    end
  end

  // Capture stage; a sample only counts once it was taken in RUN, so data
  // seen during the lock window never reaches the FIFO.
  always_ff @(posedge RX_CLK or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      cap_q     <= '0;
      cap_vld_q <= 1'b0;
    end else begin
      cap_q     <= RX_Din;
      cap_vld_q <= run_q;
    end
  end

  assign full_c  = (wr_gray_q == (rd_gray_rx ^ FULL_MASK));
  assign wr_en_c = cap_vld_q & ~full_c;
  assign drop_c  = cap_vld_q &  full_c;

  // Next write pointer and overflow toggle; one toggle per overflow episode
  // so back-to-back drops cannot cancel each other across the crossing.
  always_comb begin
    wr_bin_d   = wr_bin_q + PW'(wr_en_c);
    wr_gray_d  = wr_bin_d ^ (wr_bin_d >> 1);
    ovf_flag_d = ovf_flag_q;
    ovf_tgl_d  = ovf_tgl_q;
    if (drop_c) begin
      ovf_flag_d = 1'b1;
      ovf_tgl_d  = ovf_tgl_q ^ ~ovf_flag_q;
    end else if (wr_en_c) begin
      ovf_flag_d = 1'b0;
    end
  end

  // Write-side pointer and overflow state registers.
  always_ff @(posedge RX_CLK or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      wr_bin_q   <= '0;
      wr_gray_q  <= '0;
      ovf_flag_q <= 1'b0;
      ovf_tgl_q  <= 1'b0;
    end else begin
      wr_bin_q   <= wr_bin_d;
      wr_gray_q  <= wr_gray_d;
      ovf_flag_q <= ovf_flag_d;
      ovf_tgl_q  <= ovf_tgl_d;
    end
  end

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge RX_CLK) begin
    if (wr_en_c) begin
      mem_q[wr_bin_q[AW-1:0]] <= cap_q;
    end
  end

  // ---------------- CLK domain ----------------
  logic [PW-1:0] rd_bin_q, rd_bin_d;
  logic [PW-1:0] rd_gray_q, rd_gray_d;
  logic [PW-1:0] wr_gray_clk;
  logic          rd_en_c;
  logic          ovf_tgl_clk;
  logic          ovf_tgl_prev_q;
  logic          ovf_q;
  logic          ovf_evt_c;

  sync2_module #(.WIDTH(PW)) u_wr_ptr_sync (
    .CLK (CLK),
    .RSTn(clk_rst_n),
    .D_i (wr_gray_q),
    .Q_o (wr_gray_clk)
  );

  sync2_module #(.WIDTH(PW)) u_rd_ptr_sync (
    .CLK (RX_CLK),
    .RSTn(rx_rst_n),
    .D_i (rd_gray_q),
    .Q_o (rd_gray_rx)
  );

  sync2_module #(.WIDTH(1)) u_ovf_sync (
    .CLK (CLK),
    .RSTn(clk_rst_n),
    .D_i (ovf_tgl_q),
    .Q_o (ovf_tgl_clk)
  );

  sync2_module #(.WIDTH(1)) u_lock_sync (
    .CLK (CLK),
    .RSTn(clk_rst_n),
    .D_i (run_q),
    .Q_o (Locked)
  );

  assign Dout_Valid = (rd_gray_q != wr_gray_clk);
  assign rd_en_c    = Dout_Valid & Dout_Ready;
  assign Dout       = mem_q[rd_bin_q[AW-1:0]];
  assign ovf_evt_c  = ovf_tgl_clk ^ ovf_tgl_prev_q;
  assign Overflow   = ovf_q;

  // Next read pointer in binary and Gray form.
  always_comb begin
    rd_bin_d  = rd_bin_q + PW'(rd_en_c);
    rd_gray_d = rd_bin_d ^ (rd_bin_d >> 1);
  end

  // Read pointer plus sticky overflow; a new event wins over a clear.
  always_ff @(posedge CLK or negedge clk_rst_n) begin
    if (!clk_rst_n) begin
      rd_bin_q       <= '0;
      rd_gray_q      <= '0;
      ovf_tgl_prev_q <= 1'b0;
      ovf_q          <= 1'b0;
    end else begin
      rd_bin_q       <= rd_bin_d;
      rd_gray_q      <= rd_gray_d;
      ovf_tgl_prev_q <= ovf_tgl_clk;
      if (ovf_evt_c) begin
        ovf_q <= 1'b1;
      end else if (Ovf_Clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_src_sync_rx_module.sv
// Scoreboard bench for src_sync_rx_module: RX stimulus pushes expected
// words, a CLK-side monitor pops and compares on every handshake.
`timescale 1ns/1ps
module tb_src_sync_rx_module;

  localparam int unsigned WIDTH    = 4;
  localparam int unsigned AW       = 3;
  localparam int unsigned LOCK_CNT = 4;

  logic             CLK        = 1'b0;
  logic             RSTn       = 1'b0;
  logic             RX_CLK     = 1'b0;
  logic             Dout_Ready = 1'b0;
  logic             Ovf_Clr    = 1'b0;
  logic [WIDTH-1:0] RX_Din     = '0;
  logic [WIDTH-1:0] Dout;
  logic             Dout_Valid;
  logic             Overflow;
  logic             Locked;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  int edge_n   = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] pend = '0;
  bit   pend_vld    = 1'b0;
  bit   last_wrote  = 1'b0;
  bit   stream_done = 1'b0;
  realtime last_edge_t = 0.0;

  src_sync_rx_module #(
    .WIDTH   (WIDTH),
    .AW      (AW),
    .LOCK_CNT(LOCK_CNT)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .RX_CLK    (RX_CLK),
    .RX_Din    (RX_Din),
    .Dout      (Dout),
    .Dout_Valid(Dout_Valid),
    .Dout_Ready(Dout_Ready),
    .Overflow  (Overflow),
    .Ovf_Clr   (Ovf_Clr),
    .Locked    (Locked)
  );

  // 37 MHz system clock
  initial forever #13.5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Monitor: a handshake seen here completes on the next CLK rising edge.
  always @(negedge CLK) begin
    if (RSTn && Dout_Valid === 1'b1 && Dout_Ready === 1'b1) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word got=%0h want=none", Dout);
      end else begin
        check("dout_word", Dout, exp_q.pop_front());
      end
    end
  end

  // One forwarded-clock rising edge at 50 MHz. Model: an edge in RUN stores
  // the sample captured on the previous edge; samples from the lock window
  // are discarded. keep=0 marks a word expected to be dropped (FIFO full).
  task automatic rx_edge(input logic [WIDTH-1:0] din, input bit keep);
    RX_Din = din;
    #10 RX_CLK = 1'b1;
    last_edge_t = $realtime;
    edge_n++;
    last_wrote = pend_vld && keep;
    if (last_wrote) exp_q.push_back(pend);
    pend     = din;
    pend_vld = (edge_n > LOCK_CNT);
    #10 RX_CLK = 1'b0;
  endtask

  task automatic reset_assert();
    @(posedge CLK);
    #2;
    RSTn       = 1'b0;
    Dout_Ready = 1'b0;
    Ovf_Clr    = 1'b0;
  endtask

  // Release reset; the RX domain needs two forwarded edges to leave reset.
  task automatic reset_release();
    @(posedge CLK);
    #2 RSTn = 1'b1;
    exp_q.delete();
    pend_vld = 1'b0;
    edge_n   = 0;
    repeat (2) begin
      RX_Din = '0;
      #10 RX_CLK = 1'b1;
      #10 RX_CLK = 1'b0;
    end
    repeat (3) @(posedge CLK);
    #2;
  endtask

  task automatic set_ready(input logic v);
    @(posedge CLK);
    #2 Dout_Ready = v;
  endtask

  task automatic lock_and_check();
    int n;
    for (int i = 0; i < int'(LOCK_CNT) - 1; i++) rx_edge(4'hF, 1'b1);
    repeat (4) @(posedge CLK);
    #1;
    check("locked_early", Locked, 0);
    rx_edge(4'hF, 1'b1);
    n = 0;
    while (Locked !== 1'b1 && n < 4) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("locked_rise", Locked, 1);
    repeat (3) @(posedge CLK);
    #1;
    check("valid_in_lock", Dout_Valid, 0);
  endtask

  // Time from the write edge to the handshake that consumes that word.
  task automatic measure_latency(input string name);
    int p0;
    int n;
    realtime lat;
    p0 = pops;
    n  = 0;
    while (pops == p0 && n < 400) begin
      #1;
      n++;
    end
    lat = $realtime - last_edge_t;
    checks++;
    if (pops == p0 || lat < 27.0 || lat > 122.0) begin
      failures++;
      $display("FAIL %s got=%0.1fns want=27..122ns", name, lat);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge CLK);
      n++;
    end
    repeat (5) @(posedge CLK);
    #1;
    check(name, exp_q.size(), 0);
    check($sformatf("%s_idle", name), Dout_Valid, 0);
  endtask

  initial begin
    int p0;
    int n;
    bit saw;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_valid", Dout_Valid, 0);
    check("rst_overflow", Overflow, 0);
    check("rst_locked", Locked, 0);
    reset_release();

    // Lock window, then three words with Dout_Ready high
    lock_and_check();
    set_ready(1'b1);
    rx_edge(4'h1, 1'b1);
    for (int w = 2; w <= 4; w++) begin
      rx_edge((w == 4) ? 4'h0 : WIDTH'(w), 1'b1);
      measure_latency($sformatf("latency_w%0d", w - 1));
      repeat (6) @(posedge CLK);
    end
    wait_drain("drain_three");

    // Ten words into a stalled reader: first eight kept, 9 and 10 dropped
    reset_assert();
    reset_release();
    lock_and_check();
    for (int i = 1; i <= 11; i++) rx_edge((i == 11) ? 4'h0 : WIDTH'(i), (i - 1) <= 8);
    n = 0;
    while (Overflow !== 1'b1 && n < 10) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("overflow_set", Overflow, 1);
    check("full_head", Dout, 4'h1);

    // Ovf_Clr pulse clears on the next cycle
    @(posedge CLK);
    #2 Ovf_Clr = 1'b1;
    @(posedge CLK);
    #2 Ovf_Clr = 1'b0;
    check("ovf_clr", Overflow, 0);
    set_ready(1'b1);
    wait_drain("drain_eight");

    // New overflow event while Ovf_Clr is held: the set must win once
    reset_assert();
    reset_release();
    lock_and_check();
    @(posedge CLK);
    #2 Ovf_Clr = 1'b1;
    for (int i = 1; i <= 10; i++) rx_edge((i == 10) ? 4'h0 : WIDTH'(i), (i - 1) <= 8);
    saw = 1'b0;
    repeat (15) begin
      @(posedge CLK);
      #1;
      if (Overflow === 1'b1) saw = 1'b1;
    end
    check("ovf_set_wins", saw, 1);
    @(posedge CLK);
    #2 Ovf_Clr = 1'b0;
    @(posedge CLK);
    #1;
    check("ovf_after_clr", Overflow, 0);
    set_ready(1'b1);
    wait_drain("drain_after_clr");

    // 100 incrementing words with random Dout_Ready
    reset_assert();
    reset_release();
    lock_and_check();
    p0 = pops;
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i <= 100; i++) begin
          int g;
          g = 0;
          while (exp_q.size() >= 3 && g < 400) begin
            #5;
            g++;
          end
          if (g >= 400) begin
            checks++;
            failures++;
            $display("FAIL stream_stall got=%0d want=<3", exp_q.size());
          end
          rx_edge((i < 100) ? WIDTH'(i) : 4'h0, 1'b1);
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge CLK);
          #2 Dout_Ready = 1'($urandom_range(0, 1));
        end
      end
    join
    set_ready(1'b1);
    wait_drain("drain_stream");
    check("stream_count", pops - p0, 100);

    // Reset with five words queued; afterwards only new words appear
    reset_assert();
    reset_release();
    lock_and_check();
    for (int i = 1; i <= 6; i++) rx_edge((i == 6) ? 4'h0 : WIDTH'(i), 1'b1);
    repeat (6) @(posedge CLK);
    #1;
    check("queued_before_rst", Dout_Valid, 1);
    @(posedge CLK);
    #2 RSTn = 1'b0;
    #1;
    check("valid_in_reset", Dout_Valid, 0);
    check("locked_in_reset", Locked, 0);
    reset_release();
    check("valid_after_rst", Dout_Valid, 0);
    check("locked_after_rst", Locked, 0);
    lock_and_check();
    set_ready(1'b1);
    rx_edge(4'h7, 1'b1);
    rx_edge(4'h8, 1'b1);
    rx_edge(4'h9, 1'b1);
    rx_edge(4'h0, 1'b1);
    wait_drain("drain_new");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
